// File: rtl/n9bit_window_decoder.sv
// Window/terminal-count decoder and continuity checker for a 9-bit up/down position counter.
// Optional macro N9WD_EDGE_PULSE_EN adds win_rise/win_fall one-clk edge pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACQUIRE| no reference yet; next event seeds the expected position
// ST_TRACK  | locked; each event is compared against the expected value
module n9bit_window_decoder #(
   parameter int NUM_WIN = 4
) (
   input  logic                   clk,
   input  logic                   Reset_n,
   input  logic                   cen,
   input  logic [8:0]             count,
   input  logic                   direction,
   input  logic [9*NUM_WIN-1:0]   win_start,
   input  logic [9*NUM_WIN-1:0]   win_end,
   input  logic                   err_clr,
   output logic [NUM_WIN-1:0]     win,
   output logic                   tc,
   output logic                   sync_err,
   output logic                   locked
`ifdef N9WD_EDGE_PULSE_EN
   ,
   output logic [NUM_WIN-1:0]     win_rise,
   output logic [NUM_WIN-1:0]     win_fall
`endif
);

   typedef enum logic {
      ST_ACQUIRE = 1'b0,
      ST_TRACK   = 1'b1
   } state_t;

   state_t               r_state;
   logic                 r_last_cen;
   logic [8:0]           r_expected;
   logic                 r_locked;
   logic                 r_sync_err;
   logic                 r_tc;
   logic [NUM_WIN-1:0]   r_win;
   logic [NUM_WIN-1:0]   r_degen;

   logic                 w_ev;
   logic [8:0]           w_next_cnt;
   logic                 w_tc_hit;
   logic                 w_mismatch;
   logic [NUM_WIN-1:0]   w_hit_start;
   logic [NUM_WIN-1:0]   w_hit_end;
   logic [NUM_WIN-1:0]   w_win_next;
   logic [NUM_WIN-1:0]   w_degen_next;

   assign w_ev       = cen & ~r_last_cen;
   assign w_next_cnt = direction ? (count + 9'd1) : (count - 9'd1);
   assign w_tc_hit   = (direction & (count == 9'd511)) | (~direction & (count == 9'd0));
   assign w_mismatch = w_ev & (r_state == ST_TRACK) & (count != r_expected);

   genvar g;
   generate
      for (g = 0; g < NUM_WIN; g++) begin : g_cmp
         assign w_hit_start[g] = (count == win_start[9*g +: 9]);
         assign w_hit_end[g]   = (count == win_end[9*g +: 9]);
      end
   endgenerate

   // r_degen marks a window opened by a start==end match so the next event closes it.
   always_comb begin
      w_win_next   = r_win;
      w_degen_next = r_degen;
      if (w_ev) begin
         for (int i = 0; i < NUM_WIN; i++) begin
            if (w_hit_start[i] && w_hit_end[i]) begin
               w_win_next[i]   = 1'b1;
               w_degen_next[i] = 1'b1;
            end else if (w_hit_start[i]) begin
               w_win_next[i]   = 1'b1;
               w_degen_next[i] = 1'b0;
            end else if (w_hit_end[i] || r_degen[i]) begin
               w_win_next[i]   = 1'b0;
               w_degen_next[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_win   <= '0;
         r_degen <= '0;
      end else begin
         r_win   <= w_win_next;
         r_degen <= w_degen_next;
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_last_cen <= 1'b1;
         r_state    <= ST_ACQUIRE;
         r_expected <= 9'd0;
         r_locked   <= 1'b0;
         r_sync_err <= 1'b0;
         r_tc       <= 1'b0;
      end else begin
         r_last_cen <= cen;
         if (w_ev) r_tc <= w_tc_hit;
         // a mismatch on the same edge as err_clr keeps the error set
         if (w_mismatch)   r_sync_err <= 1'b1;
         else if (err_clr) r_sync_err <= 1'b0;
         if (w_ev) begin
            case (r_state)
               ST_ACQUIRE: begin
                  r_expected <= w_next_cnt;
                  r_locked   <= 1'b1;
                  r_state    <= ST_TRACK;
               end
               ST_TRACK: begin
                  r_expected <= w_next_cnt;
               end
               default: r_state <= ST_ACQUIRE;
            endcase
         end
      end
   end

   assign win      = r_win;
   assign tc       = r_tc;
   assign sync_err = r_sync_err;
   assign locked   = r_locked;

`ifdef N9WD_EDGE_PULSE_EN
   logic [NUM_WIN-1:0] r_win_rise;
   logic [NUM_WIN-1:0] r_win_fall;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_win_rise <= '0;
         r_win_fall <= '0;
      end else begin
         r_win_rise <= w_win_next & ~r_win;
         r_win_fall <= ~w_win_next & r_win;
      end
   end

   assign win_rise = r_win_rise;
   assign win_fall = r_win_fall;
`endif

endmodule

// File: tb/tb_n9bit_window_decoder.sv
// Scoreboard bench for n9bit_window_decoder: a behavioural model pushes expected
// outputs per event, which are popped and compared once the DUT has updated.
module tb_n9bit_window_decoder;
   localparam int NW = 4;

   logic              clk = 1'b0;
   logic              Reset_n;
   logic              cen;
   logic [8:0]        count;
   logic              direction;
   logic [9*NW-1:0]   win_start;
   logic [9*NW-1:0]   win_end;
   logic              err_clr;
   logic [NW-1:0]     win;
   logic              tc;
   logic              sync_err;
   logic              locked;
`ifdef N9WD_EDGE_PULSE_EN
   logic [NW-1:0]     win_rise;
   logic [NW-1:0]     win_fall;
`endif

   n9bit_window_decoder #(.NUM_WIN(NW)) dut (
      .clk       (clk),
      .Reset_n   (Reset_n),
      .cen       (cen),
      .count     (count),
      .direction (direction),
      .win_start (win_start),
      .win_end   (win_end),
      .err_clr   (err_clr),
      .win       (win),
      .tc        (tc),
      .sync_err  (sync_err),
      .locked    (locked)
`ifdef N9WD_EDGE_PULSE_EN
      ,
      .win_rise  (win_rise),
      .win_fall  (win_fall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NW-1:0] win;
      logic          tc;
      logic          err;
      logic          locked;
   } exp_t;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_errors = 0;

   logic [8:0]    ws [NW];
   logic [8:0]    we [NW];
   logic [NW-1:0] m_win, m_degen;
   logic          m_tc, m_err, m_locked, m_track;
   logic [8:0]    m_exp;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
      end
   endtask

   function automatic void model_reset();
      m_win = '0; m_degen = '0; m_tc = 1'b0; m_err = 1'b0;
      m_locked = 1'b0; m_track = 1'b0; m_exp = 9'd0;
   endfunction

   function automatic void model_ev(input logic [8:0] c, input logic d, input logic clr);
      exp_t e;
      for (int i = 0; i < NW; i++) begin
         if (c == ws[i] && c == we[i]) begin
            m_win[i] = 1'b1; m_degen[i] = 1'b1;
         end else if (c == ws[i]) begin
            m_win[i] = 1'b1; m_degen[i] = 1'b0;
         end else if (c == we[i] || m_degen[i]) begin
            m_win[i] = 1'b0; m_degen[i] = 1'b0;
         end
      end
      m_tc = (d && c == 9'd511) || (!d && c == 9'd0);
      if (m_track && c != m_exp) m_err = 1'b1;
      else if (clr)              m_err = 1'b0;
      m_exp    = d ? 9'(c + 9'd1) : 9'(c - 9'd1);
      m_track  = 1'b1;
      m_locked = 1'b1;
      e.win = m_win; e.tc = m_tc; e.err = m_err; e.locked = m_locked;
      sb_q.push_back(e);
   endfunction

   task automatic check_now(input string tag);
      chk({tag, ".win"},    32'(win),      32'(m_win));
      chk({tag, ".tc"},     32'(tc),       32'(m_tc));
      chk({tag, ".err"},    32'(sync_err), 32'(m_err));
      chk({tag, ".locked"}, 32'(locked),   32'(m_locked));
   endtask

   // one event: cen high for one clk, then three clk low
   task automatic do_ev(input logic [8:0] c, input logic d, input logic clr);
      exp_t e;
      @(negedge clk);
      count = c; direction = d; cen = 1'b1; err_clr = clr;
      model_ev(c, d, clr);
      @(negedge clk);
      cen = 1'b0; err_clr = 1'b0;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("ev%0d.win", c),    32'(win),      32'(e.win));
         chk($sformatf("ev%0d.tc", c),     32'(tc),       32'(e.tc));
         chk($sformatf("ev%0d.err", c),    32'(sync_err), 32'(e.err));
         chk($sformatf("ev%0d.locked", c), 32'(locked),   32'(e.locked));
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      cen = 1'b0; err_clr = 1'b0; Reset_n = 1'b0;
      #2 Reset_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      err_clr = 1'b1;
      m_err = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      check_now("clr");
   endtask

   initial begin
      ws[0] = 9'd10;  we[0] = 9'd20;
      ws[1] = 9'd50;  we[1] = 9'd50;
      ws[2] = 9'd5;   we[2] = 9'd400;
      ws[3] = 9'd511; we[3] = 9'd511;
      for (int i = 0; i < NW; i++) begin
         win_start[9*i +: 9] = ws[i];
         win_end[9*i +: 9]   = we[i];
      end
      Reset_n = 1'b0; cen = 1'b1; count = 9'd0; direction = 1'b1; err_clr = 1'b0;
      model_reset();
      #12;
      check_now("reset");
      Reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_now("cen_high_thru_reset");
      cen = 1'b0;
      @(negedge clk);

      // window set/clear on an up count
      for (int k = 0; k < 26; k++) do_ev(9'(k), 1'b1, 1'b0);
      chk("win0_closed", 32'(win[0]), 32'd0);

      // up-count wrap
      do_reset();
      for (int k = 509; k < 514; k++) do_ev(9'(k % 512), 1'b1, 1'b0);

      // down-count wrap
      do_reset();
      do_ev(9'd2, 1'b0, 1'b0);
      do_ev(9'd1, 1'b0, 1'b0);
      do_ev(9'd0, 1'b0, 1'b0);
      do_ev(9'd511, 1'b0, 1'b0);

      // load detection, clear, clear colliding with mismatch, direction change
      do_reset();
      do_ev(9'd100, 1'b1, 1'b0);
      do_ev(9'd101, 1'b1, 1'b0);
      do_ev(9'd300, 1'b1, 1'b0);
      do_ev(9'd301, 1'b1, 1'b0);
      clr_pulse();
      do_ev(9'd302, 1'b1, 1'b0);
      do_ev(9'd303, 1'b1, 1'b0);
      do_ev(9'd50, 1'b1, 1'b1);
      do_ev(9'd51, 1'b1, 1'b0);
      clr_pulse();
      do_ev(9'd50, 1'b0, 1'b0);
      do_ev(9'd49, 1'b0, 1'b0);

      // cen held high across count changes: a single event
      do_reset();
      @(negedge clk);
      count = 9'd48; direction = 1'b1; cen = 1'b1;
      model_ev(9'd48, 1'b1, 1'b0);
      void'(sb_q.pop_front());
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_now($sformatf("stuck%0d", k));
         count = 9'(49 + k);
      end
      cen = 1'b0;
      @(negedge clk);
      do_ev(9'd49, 1'b1, 1'b0);
      do_ev(9'd50, 1'b1, 1'b0);
      do_ev(9'd51, 1'b1, 1'b0);

      // asynchronous reset mid-window
      do_reset();
      do_ev(9'd10, 1'b1, 1'b0);
      do_ev(9'd30, 1'b1, 1'b0);
      @(posedge clk);
      #3 Reset_n = 1'b0; cen = 1'b1;
      #1;
      model_reset();
      check_now("async_rst");
      @(negedge clk);
      Reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_now("rst_cen_high");
      cen = 1'b0;
      @(negedge clk);
      do_ev(9'd5, 1'b1, 1'b0);
      do_ev(9'd6, 1'b1, 1'b0);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
